// File: rtl/sipo_deserializer_pkg.sv
// Shared defaults for the SIPO deserializer slice.
// Holds only elaboration-time constants; no logic.
package sipo_deserializer_pkg;

    localparam int unsigned SIPO_DEFAULT_WIDTH     = 4;
    localparam bit          SIPO_DEFAULT_MSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_deserializer_shift_core.sv
// sipo_shift_core: serial shift register and bit counter.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   sin, sin_en  - serial bit and its qualifier
//   clr          - synchronous flush of the partial word
//   word         - completed word, including the current sin (valid with complete)
//   complete     - high on the cycle the last bit of a word is sampled
//   busy         - partial word holds at least one bit
module sipo_shift_core
    import sipo_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = SIPO_DEFAULT_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             clr,
    output logic [WIDTH-1:0] word,
    output logic             complete,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_shift_next;
    logic             w_last_bit;

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shift_next = {r_shift[WIDTH-2:0], sin};
        end else begin : g_lsb
            assign w_shift_next = {sin, r_shift[WIDTH-1:1]};
        end
    endgenerate

    assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (clr) begin
            // flush wins over a same-cycle sin_en
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (sin_en) begin
            r_shift <= w_shift_next;
            r_cnt   <= w_last_bit ? '0 : r_cnt + CW'(1);
        end
    end

    assign word     = w_shift_next;
    assign complete = sin_en & ~clr & w_last_bit;
    assign busy     = (r_cnt != '0);

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in, parallel-out receiver with one-word holding
// register and ready/valid output.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   sin, sin_en - serial bit and its qualifier
//   clr         - synchronous flush of partial word and overrun flag
//   pout        - held word (meaningful while pout_valid)
//   pout_valid  - holding register has an unconsumed word
//   pout_ready  - consumer accepts on pout_valid & pout_ready
//   busy        - partial word holds at least one bit
//   overrun     - sticky: a completed word was dropped
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = SIPO_DEFAULT_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             clr,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             overrun
);

    logic [WIDTH-1:0] w_word;
    logic             w_complete;
    logic             w_busy;
    logic             w_hold_free;

    logic [WIDTH-1:0] r_pout;
    logic             r_valid;
    logic             r_overrun;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .sin      (sin),
        .sin_en   (sin_en),
        .clr      (clr),
        .word     (w_word),
        .complete (w_complete),
        .busy     (w_busy)
    );

    // accept and reload may share an edge, so no bubble under full throughput
    assign w_hold_free = ~r_valid | pout_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pout  <= '0;
            r_valid <= 1'b0;
        end else if (w_complete && w_hold_free) begin
            r_pout  <= w_word;
            r_valid <= 1'b1;
        end else if (r_valid && pout_ready) begin
            r_valid <= 1'b0;
        end
    end

    // complete is already gated by clr, so clear and set never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (clr) begin
            r_overrun <= 1'b0;
        end else if (w_complete && !w_hold_free) begin
            r_overrun <= 1'b1;
        end
    end

    assign pout       = r_pout;
    assign pout_valid = r_valid;
    assign busy       = w_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sin = 1'b0;
    logic         sin_en = 1'b0;
    logic         clr = 1'b0;
    logic         pout_ready = 1'b0;
    logic [W-1:0] pout_m, pout_l;
    logic         valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en), .clr(clr),
        .pout(pout_m), .pout_valid(valid_m), .pout_ready(pout_ready),
        .busy(busy_m), .overrun(ovr_m)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en), .clr(clr),
        .pout(pout_l), .pout_valid(valid_l), .pout_ready(pout_ready),
        .busy(busy_l), .overrun(ovr_l)
    );

    // ---------------- reference model: list of received bits ----------------
    int       m_bits[$];
    int       m_pout_m, m_pout_l;
    bit       m_valid, m_ovr;

    task automatic model_reset();
        m_bits.delete();
        m_pout_m = 0;
        m_pout_l = 0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit e, input bit c, input bit r);
        bit took;
        bit free;
        int wm, wl;
        free = !m_valid || r;
        took = 1'b0;
        if (c) begin
            m_bits.delete();
            m_ovr = 1'b0;
        end else if (e) begin
            m_bits.push_back(int'(s));
            if (m_bits.size() == W) begin
                wm = 0;
                wl = 0;
                for (int i = 0; i < W; i++) begin
                    wm += m_bits[i] * (1 << (W - 1 - i));
                    wl += m_bits[i] * (1 << i);
                end
                m_bits.delete();
                if (free) begin
                    m_pout_m = wm;
                    m_pout_l = wl;
                    m_valid  = 1'b1;
                    took     = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        if (!took && m_valid && r) m_valid = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, " pout_m"},  int'(pout_m),  m_pout_m);
        chk({tag, " pout_l"},  int'(pout_l),  m_pout_l);
        chk({tag, " valid_m"}, int'(valid_m), int'(m_valid));
        chk({tag, " valid_l"}, int'(valid_l), int'(m_valid));
        chk({tag, " busy_m"},  int'(busy_m),  int'(m_bits.size() != 0));
        chk({tag, " busy_l"},  int'(busy_l),  int'(m_bits.size() != 0));
        chk({tag, " ovr_m"},   int'(ovr_m),   int'(m_ovr));
        chk({tag, " ovr_l"},   int'(ovr_l),   int'(m_ovr));
    endtask

    // called at a negedge; drives, lets one rising edge pass, samples at next negedge
    task automatic cyc(input string tag, input bit s, input bit e, input bit c, input bit r);
        sin = s; sin_en = e; clr = c; pout_ready = r;
        @(posedge clk);
        model_step(s, e, c, r);
        @(negedge clk);
        compare_model(tag);
    endtask

    task automatic send_word(input string tag, input logic [3:0] w, input bit r);
        logic [3:0] v;
        v = w;
        for (int i = W - 1; i >= 0; i--) cyc(tag, v[i], 1'b1, 1'b0, r);
    endtask

    typedef struct {
        bit         s, e, c, r;
        logic [3:0] pm, pl;
        bit         v, b, o;
    } vec_t;

    vec_t tbl[6];

    initial begin
        // basic word 1,0,1,1 with ready high; valid for exactly one cycle
        tbl[0] = '{s:1, e:1, c:0, r:1, pm:4'h0, pl:4'h0, v:0, b:1, o:0};
        tbl[1] = '{s:0, e:1, c:0, r:1, pm:4'h0, pl:4'h0, v:0, b:1, o:0};
        tbl[2] = '{s:1, e:1, c:0, r:1, pm:4'h0, pl:4'h0, v:0, b:1, o:0};
        tbl[3] = '{s:1, e:1, c:0, r:1, pm:4'b1011, pl:4'b1101, v:1, b:0, o:0};
        tbl[4] = '{s:0, e:0, c:0, r:1, pm:4'b1011, pl:4'b1101, v:0, b:0, o:0};
        tbl[5] = '{s:1, e:0, c:0, r:1, pm:4'b1011, pl:4'b1101, v:0, b:0, o:0};

        model_reset();
        repeat (3) @(negedge clk);
        chk("reset pout_m", int'(pout_m), 0);
        chk("reset valid",  int'(valid_m), 0);
        chk("reset busy",   int'(busy_m), 0);
        chk("reset ovr",    int'(ovr_m), 0);
        rst_n = 1'b1;
        repeat (10) cyc("idle", 1'($urandom), 1'b0, 1'b0, 1'b1);
        chk("idle valid", int'(valid_m), 0);
        chk("idle busy",  int'(busy_m), 0);

        for (int i = 0; i < 6; i++) begin
            cyc("tbl", tbl[i].s, tbl[i].e, tbl[i].c, tbl[i].r);
            chk($sformatf("tbl%0d pout_m", i), int'(pout_m), int'(tbl[i].pm));
            chk($sformatf("tbl%0d pout_l", i), int'(pout_l), int'(tbl[i].pl));
            chk($sformatf("tbl%0d valid", i),  int'(valid_m), int'(tbl[i].v));
            chk($sformatf("tbl%0d busy", i),   int'(busy_m), int'(tbl[i].b));
            chk($sformatf("tbl%0d ovr", i),    int'(ovr_m), int'(tbl[i].o));
        end

        // gapped input, random sin on idle cycles
        begin
            logic [3:0] gb;
            gb = 4'b1011;
            for (int i = W - 1; i >= 0; i--) begin
                cyc("gap", gb[i], 1'b1, 1'b0, 1'b1);
                if (i != 0) begin
                    chk("gap busy on", int'(busy_m), 1);
                    cyc("gap idle", 1'($urandom), 1'b0, 1'b0, 1'b1);
                    chk("gap busy idle", int'(busy_m), 1);
                end
            end
            chk("gap pout", int'(pout_m), 4'hB);
            chk("gap valid", int'(valid_m), 1);
            chk("gap busy done", int'(busy_m), 0);
            cyc("gap drain", 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // back-pressure and overrun
        send_word("bp3", 4'h3, 1'b0);
        chk("bp pend pout", int'(pout_m), 4'h3);
        send_word("bpA", 4'hA, 1'b0);
        chk("bp hold pout", int'(pout_m), 4'h3);
        chk("bp hold valid", int'(valid_m), 1);
        chk("bp overrun", int'(ovr_m), 1);
        cyc("bp accept", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp accepted valid", int'(valid_m), 0);
        chk("bp ovr sticky", int'(ovr_m), 1);
        cyc("bp clr", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp clr ovr", int'(ovr_m), 0);

        // accept-and-reload on the completing edge
        send_word("ar5", 4'h5, 1'b0);
        cyc("ar6", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("ar6", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("ar6", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("ar6", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("ar pout", int'(pout_m), 4'h6);
        chk("ar valid", int'(valid_m), 1);
        chk("ar ovr", int'(ovr_m), 0);
        cyc("ar drain", 1'b0, 1'b0, 1'b0, 1'b1);

        // flush with simultaneous sin_en
        cyc("fl", 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("fl", 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("fl clr", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("fl busy", int'(busy_m), 0);
        send_word("fl6", 4'b0110, 1'b1);
        chk("fl pout", int'(pout_m), 4'b0110);
        chk("fl valid", int'(valid_m), 1);

        // asynchronous reset mid-word with a word pending
        cyc("rs", 1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst pout", int'(pout_m), 0);
        chk("arst valid", int'(valid_m), 0);
        chk("arst busy", int'(busy_m), 0);
        chk("arst ovr", int'(ovr_m), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) cyc("post rst", 1'($urandom), 1'b0, 1'b0, 1'($urandom));
        chk("post rst valid", int'(valid_m), 0);
        chk("post rst busy", int'(busy_m), 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rnd", 1'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
